mito_layer_sequencer: RTL and testbench
=======================================

# mito_layer_sequencer

Layer-level sequencer for the MITO accelerator datapath. It runs one layer at a time: on `start` it drives the load strobes of the IFM, weight and bias buffers, gates the PE array for a fixed compute latency, and hands each output pixel to the OFM buffer with a valid/ready handshake. It repeats this for a programmed number of output pixels, then pulses `done`. It sits between the host/top-level control and the `ifm_buffer`/`wgt_buffer`/`bias_buffer`/`pe_array`/`max_pooling` path, and supplies the `mode` select for the ReLU/pool output mux.

## Interface
Parameters:
- `PE_LAT`, 2: compute cycles per pixel (PE array + ReLU/pool pipeline depth); must be ≥1.
- `CNT_W`, 16: width of the pixel counter.
- `INPUT_REG`, 3: number of row loads per window for CONVOL/FULLY; also the number of weight loads.
- `CONVOL`, 2'b01; `FULLY`, 2'b10; `POOL`, 2'b11: layer-type codes. 2'b00 is invalid.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  layer start request; sampled only in IDLE.
- `abort`  in  1  synchronous abort; returns to IDLE.
- `layer_type`  in  2  layer code; latched on start.
- `out_count`  in  CNT_W  output pixels in the layer; latched on start.
- `ofm_ready`  in  1  OFM buffer can accept.
- `ifm_read`  out  4  [2:0] row-load strobes (one-hot); [3] window clear.
- `wgt_read`  out  1  weight row load strobe.
- `bias_read`  out  1  bias load strobe.
- `pe_en`  out  1  PE array enable.
- `mode`  out  2  latched layer type; selects pool vs ReLU output.
- `ofm_valid`  out  1  output pixel available.
- `out_idx`  out  CNT_W  index of the current pixel.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle completion pulse.

## Operation
- All outputs are registered. Reset value of every output is 0, and the state is IDLE.
- States: IDLE, CLEAR, LOAD_WGT, LOAD_BIAS, LOAD_IFM, COMPUTE, WRITE, DONE.
- IDLE:
  - `start`=1 with a valid `layer_type` latches `mode`/`out_count`, clears `out_idx`, and goes to CLEAR.
  - `start` with `layer_type`=00 is ignored.
  - `start` with `out_count`=0 goes directly to DONE.
- CLEAR (1 cycle): `ifm_read`=4'b1000. The next state is LOAD_WGT for CONVOL/FULLY and LOAD_IFM for POOL.
- LOAD_WGT: `wgt_read`=1 for INPUT_REG consecutive cycles, then LOAD_BIAS.
- LOAD_BIAS (1 cycle): `bias_read`=1, then LOAD_IFM.
- LOAD_IFM:
  - CONVOL/FULLY: `ifm_read` steps 0001, 0010, 0100 over INPUT_REG cycles.
  - POOL: 0001, 0010 over 2 cycles.
  - Next state is COMPUTE.
- COMPUTE: lasts PE_LAT cycles. `pe_en`=1 for CONVOL/FULLY; `pe_en`=0 for POOL. Then WRITE.
- WRITE:
  - `ofm_valid`=1 and held until `ofm_ready`=1; the transfer happens on the edge where both are 1.
  - If `out_idx` = `out_count`-1, go to DONE.
  - Otherwise increment `out_idx` and go to the reload state given under Configuration.
- DONE (1 cycle): `done`=1, `busy`=1, then IDLE.
- `mode` holds its value after `done` until the next accepted start.
- `abort`=1 in any non-IDLE state: next state is IDLE, all strobes drop, and `done` is not pulsed. `abort` has priority over every other transition.
- `start` while busy is ignored. Changes to `layer_type`/`out_count` after acceptance have no effect.
- An async reset mid-layer forces IDLE and zero outputs immediately. No partial pixel is written.

## Timing
- Start accepted at edge N. CLEAR occupies cycle N+1.
- CONVOL with PE_LAT=2:
  - `wgt_read` in cycles N+2..N+4, `bias_read` in N+5.
  - `ifm_read` rows in N+6..N+8, `pe_en` in N+9..N+10.
  - `ofm_valid` in N+11 at the earliest.
- POOL with PE_LAT=2: `ifm_read` in N+2..N+3 and `ofm_valid` at N+6.
- Per-pixel throughput, CONVOL, `ofm_ready` always 1:
  - INPUT_REG+PE_LAT+1 = 6 cycles with weight reuse.
  - INPUT_REG+1+INPUT_REG+PE_LAT+1 = 10 cycles without reuse.
- `done` is asserted in the cycle after the final transfer edge. `busy` falls one cycle after `done`.

## Configuration
- `MITO_SEQ_WGT_REUSE_EN` defined: after each pixel, CONVOL/FULLY return to LOAD_IFM. Weights and bias load once per layer.
- `MITO_SEQ_WGT_REUSE_EN` undefined: CONVOL/FULLY return to LOAD_WGT, so weights and bias reload for every pixel.
- POOL behaves the same either way.

## Test plan
- Reset mid-LOAD_IFM → all outputs 0 immediately. State is IDLE, and a new start then behaves normally.
- CONVOL, `out_count`=3, `ofm_ready`=1, reuse defined:
  - 3 `wgt_read` and 1 `bias_read` total, 9 `ifm_read` row strobes.
  - `ofm_valid` at N+11, N+17, N+23; `done` at N+24.
- Same stimulus with reuse undefined → 9 `wgt_read`, 3 `bias_read`; `ofm_valid` at N+11, N+21, N+31.
- POOL, `out_count`=2, `ofm_ready` low for 4 cycles on pixel 0:
  - `pe_en` never asserted and `mode`=11.
  - `ofm_valid` held 5 cycles, `out_idx` goes 0→1, `done` is a single pulse.
- `start` with `out_count`=0 → `done` one cycle after acceptance, with no strobes. `start` with `layer_type`=00 → stays IDLE.
- `abort` during COMPUTE of pixel 1 → IDLE next cycle, no `done`. `start` asserted while busy is ignored.

Source files
------------

// File: rtl/mito_layer_sequencer_if.sv
// mito_layer_sequencer_if: host/datapath control bundle for the MITO layer sequencer.
interface mito_layer_sequencer_if #(parameter int CNT_W = 16);
  logic             i_start;
  logic             i_abort;
  logic [1:0]       i_layer_type;
  logic [CNT_W-1:0] i_out_count;
  logic             i_ofm_ready;
  logic [3:0]       o_ifm_read;
  logic             o_wgt_read;
  logic             o_bias_read;
  logic             o_pe_en;
  logic [1:0]       o_mode;
  logic             o_ofm_valid;
  logic [CNT_W-1:0] o_out_idx;
  logic             o_busy;
  logic             o_done;
  modport master (output i_start, i_abort, i_layer_type, i_out_count, i_ofm_ready,
                  input o_ifm_read, o_wgt_read, o_bias_read, o_pe_en, o_mode, o_ofm_valid,
                  o_out_idx, o_busy, o_done);
  modport slave (input i_start, i_abort, i_layer_type, i_out_count, i_ofm_ready,
                 output o_ifm_read, o_wgt_read, o_bias_read, o_pe_en, o_mode, o_ofm_valid,
                 o_out_idx, o_busy, o_done);
endinterface

// File: rtl/mito_layer_sequencer.sv
// mito_layer_sequencer: per-layer load/compute/write sequencer for the MITO datapath.
// Define MITO_SEQ_WGT_REUSE_EN to load weights and bias once per layer instead of per pixel.
module mito_layer_sequencer #(
  parameter int         PE_LAT    = 2,
  parameter int         CNT_W     = 16,
  parameter int         INPUT_REG = 3,
  parameter logic [1:0] CONVOL    = 2'b01,
  parameter logic [1:0] FULLY     = 2'b10,
  parameter logic [1:0] POOL      = 2'b11
) (
  input logic                   clk,
  input logic                   rst_n,
  mito_layer_sequencer_if.slave bus
);
  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_WGT, S_BIAS, S_IFM, S_COMP, S_WRITE, S_DONE} state_t;
  localparam int CW = 8;
  state_t           r_state, w_state_nxt, w_reload;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic [1:0]       r_mode;
  logic [CNT_W-1:0] r_out_count, r_out_idx;
  logic [3:0]       r_ifm_read, w_ifm_read;
  logic             r_wgt_read, r_bias_read, r_pe_en, r_ofm_valid, r_busy, r_done;
  logic             w_pool, w_last, w_accept, w_xfer;
  assign w_pool   = r_mode == POOL;
  assign w_last   = r_out_idx == r_out_count - 1'b1;
  assign w_accept = r_state == S_IDLE && bus.i_start &&
                    (bus.i_layer_type == CONVOL || bus.i_layer_type == FULLY || bus.i_layer_type == POOL);
  assign w_xfer   = r_state == S_WRITE && bus.i_ofm_ready && !bus.i_abort;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_mode      <= '0;
      r_out_count <= '0;
      r_out_idx   <= '0;
      r_ifm_read  <= '0;
      r_wgt_read  <= 1'b0;
      r_bias_read <= 1'b0;
      r_pe_en     <= 1'b0;
      r_ofm_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_ifm_read  <= w_ifm_read;
      r_wgt_read  <= w_state_nxt == S_WGT;
      r_bias_read <= w_state_nxt == S_BIAS;
      r_pe_en     <= w_state_nxt == S_COMP && !w_pool;
      r_ofm_valid <= w_state_nxt == S_WRITE;
      r_busy      <= w_state_nxt != S_IDLE;
      r_done      <= w_state_nxt == S_DONE;
      if (w_accept) begin
        r_mode      <= bus.i_layer_type;
        r_out_count <= bus.i_out_count;
        r_out_idx   <= '0;
      end else if (w_xfer && !w_last) r_out_idx <= r_out_idx + 1'b1;
    end
  always_comb begin
`ifdef MITO_SEQ_WGT_REUSE_EN
    w_reload = S_IFM;
`else
    w_reload = w_pool ? S_IFM : S_WGT;
`endif
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = bus.i_out_count == '0 ? S_DONE : S_CLEAR;
      S_CLEAR: w_state_nxt = w_pool ? S_IFM : S_WGT;
      S_WGT:   if (r_cnt == CW'(INPUT_REG - 1)) w_state_nxt = S_BIAS;
      S_BIAS:  w_state_nxt = S_IFM;
      S_IFM:   if (r_cnt == (w_pool ? CW'(1) : CW'(INPUT_REG - 1))) w_state_nxt = S_COMP;
      S_COMP:  if (r_cnt == CW'(PE_LAT - 1)) w_state_nxt = S_WRITE;
      S_WRITE: if (bus.i_ofm_ready) w_state_nxt = w_last ? S_DONE : w_reload;
      default: w_state_nxt = S_IDLE;
    endcase
    if (bus.i_abort && r_state != S_IDLE) w_state_nxt = S_IDLE;
    w_cnt_nxt = w_state_nxt == r_state ? r_cnt + 1'b1 : '0;
  end
  // Outputs are registered from the next state, so strobes line up with the state they belong to.
  always_comb begin
    w_ifm_read = w_state_nxt == S_CLEAR ? 4'b1000 :
                 w_state_nxt == S_IFM   ? 4'(1) << w_cnt_nxt : 4'b0000;
  end
  assign bus.o_ifm_read  = r_ifm_read;
  assign bus.o_wgt_read  = r_wgt_read;
  assign bus.o_bias_read = r_bias_read;
  assign bus.o_pe_en     = r_pe_en;
  assign bus.o_mode      = r_mode;
  assign bus.o_ofm_valid = r_ofm_valid;
  assign bus.o_out_idx   = r_out_idx;
  assign bus.o_busy      = r_busy;
  assign bus.o_done      = r_done;
endmodule

// File: tb/tb_mito_layer_sequencer.sv
// tb_mito_layer_sequencer: directed checks of layer timing, stalls, abort, reset and corner starts.
module tb_mito_layer_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  mito_layer_sequencer_if #(.CNT_W(16)) bus ();
  mito_layer_sequencer dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`ifdef MITO_SEQ_WGT_REUSE_EN
  localparam int E_WGT = 3, E_BIAS = 1, E_V1 = 17, E_V2 = 23, E_DONE = 24, E_ABORT = 15;
`else
  localparam int E_WGT = 9, E_BIAS = 3, E_V1 = 21, E_V2 = 31, E_DONE = 32, E_ABORT = 19;
`endif
  int passes = 0, fails = 0, checks = 0;
  int n_wgt, n_bias, n_rows, n_clr, n_pe, n_valid, n_done, n_busy;
  int first_wgt, first_bias, first_row, first_pe, done_cyc, busy_fall;
  int vc[8];
  logic a_busy[64], a_pe[64];
  logic [1:0] a_mode[64];
  logic [15:0] a_idx[64];
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic run(input logic [1:0] t, input logic [15:0] n, input int ncyc, input int hold,
                     input int abort_c, input int restart_c);
    int nv;
    {n_wgt, n_bias, n_rows, n_clr, n_pe, n_valid, n_done, n_busy} = '0;
    {first_wgt, first_bias, first_row, first_pe, done_cyc, busy_fall} = {6{-1}};
    for (int i = 0; i < 8; i++) vc[i] = -1;
    for (int i = 0; i < 64; i++) begin a_busy[i] = 0; a_pe[i] = 0; a_mode[i] = 0; a_idx[i] = 0; end
    bus.i_layer_type = t;
    bus.i_out_count = n;
    bus.i_start = 1'b1;
    bus.i_ofm_ready = hold == 0;
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    bus.i_layer_type = 2'b11;
    bus.i_out_count = 16'd7;
    nv = 0;
    for (int k = 1; k <= ncyc; k++) begin
      a_busy[k] = bus.o_busy; a_pe[k] = bus.o_pe_en; a_mode[k] = bus.o_mode; a_idx[k] = bus.o_out_idx;
      if (bus.o_wgt_read) begin n_wgt++; if (first_wgt < 0) first_wgt = k; end
      if (bus.o_bias_read) begin n_bias++; if (first_bias < 0) first_bias = k; end
      if (|bus.o_ifm_read[2:0] && first_row < 0) first_row = k;
      n_rows += $countones(bus.o_ifm_read[2:0]);
      if (bus.o_ifm_read[3]) n_clr++;
      if (bus.o_pe_en) begin n_pe++; if (first_pe < 0) first_pe = k; end
      if (bus.o_ofm_valid) begin if (nv < 8) vc[nv] = k; nv++; n_valid++; end
      if (bus.o_done) begin n_done++; done_cyc = k; end
      if (bus.o_busy) n_busy++;
      else if (n_busy > 0 && busy_fall < 0) busy_fall = k;
      bus.i_ofm_ready = hold == 0 || nv > hold;
      bus.i_abort = k == abort_c;
      bus.i_start = k == restart_c;
      @(posedge clk); #1;
    end
    bus.i_abort = 1'b0;
    bus.i_start = 1'b0;
  endtask
  initial begin
    bus.i_start = 0; bus.i_abort = 0; bus.i_layer_type = 0; bus.i_out_count = 0; bus.i_ofm_ready = 0;
    #12;
    chk("rst_busy", bus.o_busy, 0);
    chk("rst_outs", {bus.o_ifm_read, bus.o_wgt_read, bus.o_bias_read, bus.o_pe_en, bus.o_mode,
                     bus.o_ofm_valid, bus.o_out_idx, bus.o_done}, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    // CONVOL, 3 pixels, ready always high
    run(2'b01, 16'd3, 40, 0, -1, -1);
    chk("cv_wgt", n_wgt, E_WGT);
    chk("cv_bias", n_bias, E_BIAS);
    chk("cv_rows", n_rows, 9);
    chk("cv_clr", n_clr, 1);
    chk("cv_pe", n_pe, 6);
    chk("cv_first_wgt", first_wgt, 2);
    chk("cv_first_bias", first_bias, 5);
    chk("cv_first_row", first_row, 6);
    chk("cv_first_pe", first_pe, 9);
    chk("cv_nvalid", n_valid, 3);
    chk("cv_v0", vc[0], 11);
    chk("cv_v1", vc[1], E_V1);
    chk("cv_v2", vc[2], E_V2);
    chk("cv_idx_last", a_idx[E_V2], 2);
    chk("cv_done_cyc", done_cyc, E_DONE);
    chk("cv_ndone", n_done, 1);
    chk("cv_busy_fall", busy_fall, E_DONE + 1);
    chk("cv_mode_hold", bus.o_mode, 2'b01);
    // POOL, 2 pixels, ofm_ready low for 4 cycles on pixel 0
    run(2'b11, 16'd2, 25, 4, -1, -1);
    chk("pl_pe", n_pe, 0);
    chk("pl_wgt", n_wgt + n_bias, 0);
    chk("pl_mode", a_mode[3], 2'b11);
    chk("pl_rows", n_rows, 4);
    chk("pl_nvalid", n_valid, 6);
    chk("pl_v0", vc[0], 6);
    chk("pl_v4", vc[4], 10);
    chk("pl_v5", vc[5], 15);
    chk("pl_idx0", a_idx[10], 0);
    chk("pl_idx1", a_idx[15], 1);
    chk("pl_ndone", n_done, 1);
    chk("pl_done_cyc", done_cyc, 16);
    // out_count = 0
    run(2'b01, 16'd0, 4, 0, -1, -1);
    chk("z_done_cyc", done_cyc, 1);
    chk("z_busy_fall", busy_fall, 2);
    chk("z_strobes", n_wgt + n_bias + n_rows + n_clr + n_pe + n_valid, 0);
    // invalid layer type
    run(2'b00, 16'd3, 5, 0, -1, -1);
    chk("inv_busy", n_busy, 0);
    chk("inv_done", n_done, 0);
    // abort during COMPUTE of pixel 1, with an ignored start while busy
    run(2'b01, 16'd3, 30, 0, E_ABORT, 4);
    chk("ab_pe_at", a_pe[E_ABORT], 1);
    chk("ab_busy_at", a_busy[E_ABORT], 1);
    chk("ab_busy_after", a_busy[E_ABORT + 1], 0);
    chk("ab_ndone", n_done, 0);
    chk("ab_nvalid", n_valid, 1);
    chk("ab_v0", vc[0], 11);
    chk("ab_mode", a_mode[10], 2'b01);
    // async reset in the middle of LOAD_IFM
    run(2'b01, 16'd3, 6, 0, -1, -1);
    chk("pre_rst_ifm", bus.o_ifm_read, 4'b0010);
    #3 rst_n = 1'b0;
    #1;
    chk("mid_rst_ifm", bus.o_ifm_read, 0);
    chk("mid_rst_busy", bus.o_busy, 0);
    chk("mid_rst_rest", {bus.o_wgt_read, bus.o_bias_read, bus.o_pe_en, bus.o_mode, bus.o_ofm_valid,
                         bus.o_out_idx, bus.o_done}, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    run(2'b11, 16'd1, 10, 0, -1, -1);
    chk("post_rst_v0", vc[0], 6);
    chk("post_rst_done", done_cyc, 7);
    chk("post_rst_ndone", n_done, 1);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
